// File: rtl/mem_reader_pkg.sv
// rtl/mem_reader_pkg.sv - shared state encoding, buffer depth and default widths for mem_stream_reader
package mem_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int FIFO_DEPTH = 2;

    localparam int DEF_MEMORY_BUS_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH       = 11;
    localparam int DEF_LEN_WIDTH        = 11;

endpackage

// File: rtl/mem_reader_fifo.sv
// rtl/mem_reader_fifo.sv - two-entry word buffer with push/pop/count, simultaneous push and pop allowed
module mem_reader_fifo
    import mem_reader_pkg::*;
#(
    parameter int WIDTH = DEF_MEMORY_BUS_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] store_q [FIFO_DEPTH];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic             do_push;
    logic             do_pop;

    // A pop frees a slot in the same cycle, so a full buffer still takes a push alongside a pop.
    assign do_pop  = pop && (count_q != 2'd0);
    assign do_push = push && ((count_q != 2'(FIFO_DEPTH)) || do_pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            store_q[wr_ptr_q] <= push_data;
        end
    end

    assign head_data = store_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/mem_stream_reader.sv
// rtl/mem_stream_reader.sv - sequential RAM reader streaming words out; MEM_READER_CHECKSUM_EN adds checksum_out
module mem_stream_reader
    import mem_reader_pkg::*;
#(
    parameter int MEMORY_BUS_WIDTH = DEF_MEMORY_BUS_WIDTH,
    parameter int ADDR_WIDTH       = DEF_ADDR_WIDTH,
    parameter int LEN_WIDTH        = DEF_LEN_WIDTH
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start_in,
    input  logic [ADDR_WIDTH-1:0]       base_addr_in,
    input  logic [LEN_WIDTH-1:0]        length_in,
    output logic                        busy_out,
    output logic                        done_out,
    output logic                        mem_enable_out,
    output logic [ADDR_WIDTH-1:0]       mem_addr_out,
    output logic [3:0]                  mem_wb_out,
    input  logic [MEMORY_BUS_WIDTH-1:0] mem_data_in,
    output logic                        stream_valid_out,
    output logic [MEMORY_BUS_WIDTH-1:0] stream_data_out,
    output logic                        stream_last_out,
    input  logic                        stream_ready_in
`ifdef MEM_READER_CHECKSUM_EN
    ,
    output logic [31:0]                 checksum_out
`endif
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = 1;
    localparam logic [LEN_WIDTH-1:0]  LEN_ZERO = 0;

    state_t                      state_q;
    state_t                      state_d;
    logic [ADDR_WIDTH-1:0]       next_addr_q;
    logic [LEN_WIDTH-1:0]        remaining_q;
    logic [LEN_WIDTH-1:0]        beats_left_q;
    logic                        inflight_q;
    logic [1:0]                  fifo_count;
    logic [MEMORY_BUS_WIDTH-1:0] head_data;
    logic                        accept_start;
    logic                        beat;
    logic                        issue;
    logic [2:0]                  occupancy;
    logic [2:0]                  capacity;

    mem_reader_fifo #(
        .WIDTH (MEMORY_BUS_WIDTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (inflight_q),
        .push_data (mem_data_in),
        .pop       (beat),
        .head_data (head_data),
        .count     (fifo_count)
    );

    assign accept_start = (state_q == IDLE) && start_in;
    assign beat         = stream_valid_out && stream_ready_in;

    // Only issue a read whose data is guaranteed a buffer slot when it returns next cycle.
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q};
    assign capacity  = 3'(FIFO_DEPTH) + {2'b00, beat};
    assign issue     = (state_q == RUN) && (remaining_q != LEN_ZERO) && (occupancy < capacity);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_in) begin
                    state_d = (length_in != LEN_ZERO) ? RUN : DONE;
                end
            end
            RUN: begin
                if (issue && (remaining_q == LEN_ONE)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (beat && stream_last_out) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            next_addr_q  <= '0;
            remaining_q  <= '0;
            beats_left_q <= '0;
            inflight_q   <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (accept_start) begin
                next_addr_q  <= base_addr_in;
                remaining_q  <= length_in;
                beats_left_q <= length_in;
            end else begin
                if (issue) begin
                    next_addr_q <= next_addr_q + ADDR_ONE;
                    remaining_q <= remaining_q - LEN_ONE;
                end
                if (beat) begin
                    beats_left_q <= beats_left_q - LEN_ONE;
                end
            end
        end
    end

    assign busy_out         = (state_q == RUN) || (state_q == DRAIN);
    assign done_out         = (state_q == DONE);
    assign mem_enable_out   = issue;
    assign mem_addr_out     = issue ? next_addr_q : '0;
    assign mem_wb_out       = 4'b0000;
    assign stream_valid_out = (fifo_count != 2'd0);
    assign stream_data_out  = stream_valid_out ? head_data : '0;
    assign stream_last_out  = stream_valid_out && (beats_left_q == LEN_ONE);

`ifdef MEM_READER_CHECKSUM_EN
    logic [31:0] checksum_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            checksum_q <= 32'd0;
        end else if (accept_start) begin
            checksum_q <= 32'd0;
        end else if (beat) begin
            checksum_q <= checksum_q + 32'(stream_data_out);
        end
    end

    assign checksum_out = checksum_q;
`endif

endmodule

// File: tb/tb_mem_stream_reader.sv
// tb/tb_mem_stream_reader.sv - scoreboard bench for mem_stream_reader with RAM model
module tb_mem_stream_reader;

    logic        clock = 1'b0;
    logic        reset;
    logic        start_in;
    logic [10:0] base_addr_in;
    logic [10:0] length_in;
    logic        busy_out;
    logic        done_out;
    logic        mem_enable_out;
    logic [10:0] mem_addr_out;
    logic [3:0]  mem_wb_out;
    logic [31:0] mem_data_in;
    logic        stream_valid_out;
    logic [31:0] stream_data_out;
    logic        stream_last_out;
    logic        stream_ready_in;
`ifdef MEM_READER_CHECKSUM_EN
    logic [31:0] checksum_out;
`endif

    mem_stream_reader dut (
        .clock            (clock),
        .reset            (reset),
        .start_in         (start_in),
        .base_addr_in     (base_addr_in),
        .length_in        (length_in),
        .busy_out         (busy_out),
        .done_out         (done_out),
        .mem_enable_out   (mem_enable_out),
        .mem_addr_out     (mem_addr_out),
        .mem_wb_out       (mem_wb_out),
        .mem_data_in      (mem_data_in),
        .stream_valid_out (stream_valid_out),
        .stream_data_out  (stream_data_out),
        .stream_last_out  (stream_last_out),
        .stream_ready_in  (stream_ready_in)
`ifdef MEM_READER_CHECKSUM_EN
        ,
        .checksum_out     (checksum_out)
`endif
    );

    always #5 clock = ~clock;

    logic [31:0] ram [2048];

    always @(posedge clock) begin
        if (mem_enable_out) begin
            mem_data_in <= ram[mem_addr_out];
        end
    end

    typedef struct {
        logic [10:0] addr;
        int          cyc;
    } strobe_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
        int          cyc;
    } beat_t;

    strobe_t     exp_strobes[$];
    beat_t       exp_beats[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          t0 = 0;
    int          mon_rel;
    int          strobes = 0;
    int          beats = 0;
    int          valids = 0;
    int          dones = 0;
    int          done_cyc = -1;
    int          first_beat_strobes = -1;
    int          max_out = 0;
    logic [31:0] csum_at_done = 32'd0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        mon_rel = cyc - t0;
        if (stream_valid_out && stream_ready_in) begin
            if (beats == 0) first_beat_strobes = strobes;
            beats++;
            if (exp_beats.size() == 0) begin
                check("beat_unexpected", stream_data_out, 32'hDEAD_BEEF);
            end else begin
                beat_t b;
                b = exp_beats.pop_front();
                check("beat_data", stream_data_out, b.data);
                check("beat_last", {31'd0, stream_last_out}, {31'd0, b.last});
                if (b.cyc >= 0) check("beat_cycle", mon_rel, b.cyc);
            end
        end
        if (mem_enable_out) begin
            strobes++;
            if (exp_strobes.size() == 0) begin
                check("strobe_unexpected", {21'd0, mem_addr_out}, 32'hFFFF_FFFF);
            end else begin
                strobe_t s;
                s = exp_strobes.pop_front();
                check("strobe_addr", {21'd0, mem_addr_out}, {21'd0, s.addr});
                check("strobe_wb", {28'd0, mem_wb_out}, 32'd0);
                if (s.cyc >= 0) check("strobe_cycle", mon_rel, s.cyc);
            end
        end
        if (stream_valid_out) valids++;
        if (done_out) begin
            dones++;
            done_cyc = mon_rel;
`ifdef MEM_READER_CHECKSUM_EN
            csum_at_done = checksum_out;
`endif
        end
        if (strobes - beats > max_out) max_out = strobes - beats;
    end

    task automatic expect_xfer(input logic [10:0] b, input int len, input bit timed);
        for (int i = 0; i < len; i++) begin
            logic [10:0] a;
            a = b + 11'(i);
            exp_strobes.push_back('{addr: a, cyc: timed ? i + 1 : -1});
            exp_beats.push_back('{data: ram[a], last: (i == len - 1), cyc: timed ? i + 3 : -1});
        end
    endtask

    // Returns one tick into cycle 1 of the transfer.
    task automatic start_xfer(input logic [10:0] b, input logic [10:0] l);
        @(posedge clock);
        #1;
        t0 = cyc;
        strobes = 0;
        beats = 0;
        valids = 0;
        dones = 0;
        done_cyc = -1;
        first_beat_strobes = -1;
        max_out = 0;
        start_in = 1'b1;
        base_addr_in = b;
        length_in = l;
        @(posedge clock);
        #1;
        start_in = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget, input int exp_cyc);
        int n;
        n = 0;
        while (dones == 0 && n < budget) begin
            @(posedge clock);
            n++;
        end
        repeat (2) @(posedge clock);
        #1;
        check({name, "_done_count"}, dones, 1);
        if (exp_cyc >= 0) check({name, "_done_cycle"}, done_cyc, exp_cyc);
        check({name, "_strobe_q_empty"}, exp_strobes.size(), 0);
        check({name, "_beat_q_empty"}, exp_beats.size(), 0);
        check({name, "_max_outstanding_le2"}, {31'd0, max_out <= 2}, 32'd1);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_busy"}, {31'd0, busy_out}, 32'd0);
        check({name, "_done"}, {31'd0, done_out}, 32'd0);
        check({name, "_mem_en"}, {31'd0, mem_enable_out}, 32'd0);
        check({name, "_mem_addr"}, {21'd0, mem_addr_out}, 32'd0);
        check({name, "_mem_wb"}, {28'd0, mem_wb_out}, 32'd0);
        check({name, "_valid"}, {31'd0, stream_valid_out}, 32'd0);
        check({name, "_last"}, {31'd0, stream_last_out}, 32'd0);
        check({name, "_data"}, stream_data_out, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) ram[i] = 32'h1000_0000 + i;
        ram[11'h010] = 32'd1;
        ram[11'h011] = 32'd2;
        ram[11'h012] = 32'd3;
        ram[11'h013] = 32'd4;
        ram[11'h030] = 32'hFFFF_FFFF;
        ram[11'h031] = 32'h0000_0002;
        mem_data_in = 32'd0;
        reset = 1'b1;
        start_in = 1'b0;
        base_addr_in = 11'd0;
        length_in = 11'd0;
        stream_ready_in = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_outputs_zero("reset");
`ifdef MEM_READER_CHECKSUM_EN
        check("reset_checksum", checksum_out, 32'd0);
`endif
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clock);

        // Basic 4-word transfer, ready always high.
        expect_xfer(11'h010, 4, 1'b1);
        start_xfer(11'h010, 11'd4);
        wait_done("basic", 30, 7);
        check("basic_beats", beats, 4);

        // Same transfer with consumer stalled in cycles 3..6.
        stream_ready_in = 1'b0;
        expect_xfer(11'h010, 4, 1'b0);
        start_xfer(11'h010, 11'd4);
        @(posedge clock);
        @(posedge clock);
        for (int c = 3; c <= 6; c++) begin
            @(negedge clock);
            check("stall_valid_held", {31'd0, stream_valid_out}, 32'd1);
        end
        @(posedge clock);
        #1;
        stream_ready_in = 1'b1;
        wait_done("stall", 40, 11);
        check("stall_strobes_before_first_beat", first_beat_strobes, 2);
        check("stall_beats", beats, 4);

        // Zero-length start goes straight to DONE.
        start_xfer(11'h050, 11'd0);
        wait_done("len0", 10, 1);
        check("len0_strobes", strobes, 0);
        check("len0_valids", valids, 0);

        // Address wrap at the top of the RAM.
        expect_xfer(11'h7FE, 4, 1'b1);
        start_xfer(11'h7FE, 11'd4);
        wait_done("wrap", 30, 7);

        // Reset in cycle 5 of an 8-word transfer.
        for (int i = 0; i < 5; i++) exp_strobes.push_back('{addr: 11'h100 + 11'(i), cyc: i + 1});
        for (int i = 0; i < 3; i++) exp_beats.push_back('{data: 32'h1000_0100 + i, last: 1'b0, cyc: i + 3});
        start_xfer(11'h100, 11'd8);
        repeat (4) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check_outputs_zero("midreset");
        repeat (20) @(posedge clock);
        #1;
        check("midreset_no_done", dones, 0);
        check("midreset_strobes", strobes, 5);
        check("midreset_beats", beats, 3);
        check("midreset_strobe_q_empty", exp_strobes.size(), 0);
        check("midreset_beat_q_empty", exp_beats.size(), 0);

        expect_xfer(11'h020, 2, 1'b1);
        start_xfer(11'h020, 11'd2);
        wait_done("after_reset", 20, 5);

`ifdef MEM_READER_CHECKSUM_EN
        expect_xfer(11'h030, 2, 1'b1);
        start_xfer(11'h030, 11'd2);
        wait_done("checksum", 20, 5);
        check("checksum_at_done", csum_at_done, 32'h0000_0001);
        check("checksum_stable", checksum_out, 32'h0000_0001);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
